tens: RTL and testbench
=======================

Name: tens

Overview:
- Sequential 8-bit binary to 3-digit BCD converter using the double-dabble algorithm (shift and add-3), one bit per clock.
- Produces hundreds, tens and ones digits with a start/done handshake.
- Sits between datapath counters or registers and display or decimal-formatting logic.
- The primary consumers are the tens digit (o_D1) and ones digit (o_D0); the hundreds digit (o_D2) covers inputs 100..255.

Parameters:
- None. Input width is fixed at 8 bits; output is fixed at 3 BCD digits.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  request conversion of i_bin; sampled only in IDLE.
- i_bin  input  8  unsigned binary value, 0..255; sampled on the accepting edge only.
- o_busy  output  1  high while a conversion is in progress.
- o_done  output  1  single-cycle pulse when new digits are valid.
- o_D2  output  4  hundreds BCD digit, 0..2.
- o_D1  output  4  tens BCD digit, 0..9.
- o_D0  output  4  ones BCD digit, 0..9.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low.
  - While i_rst_n=0: state=IDLE; o_busy, o_done, o_D2, o_D1 and o_D0 are all 0; internal 20-bit shift register and step counter are cleared.
- Internal shift register is 20 bits:
  - [19:16] hundreds
  - [15:12] tens
  - [11:8] ones
  - [7:0] binary
- States: IDLE, SHIFT.
- IDLE:
  - On a rising edge with i_start=1: load shift register with {12'b0, i_bin}, set step counter to 0, go to SHIFT, set o_busy=1.
  - With i_start=0: remain in IDLE.
- SHIFT, one step per rising edge:
  - Each BCD nibble (ones, tens, hundreds) that is >=5 is incremented by 3.
  - The corrections are evaluated on the pre-step values.
  - The whole 20-bit register is then shifted left by 1, with 0 shifted in.
  - The counter increments.
- Completion:
  - On the 8th step edge, register the final nibbles into o_D2, o_D1 and o_D0.
  - On the same edge: o_done=1, o_busy=0, state=IDLE.
- Latency:
  - 8 clock edges after the accepting edge.
  - o_done is high for exactly one cycle.
- Throughput: a new i_start is accepted on the edge immediately after o_done, giving one conversion per 9 cycles back-to-back.
- i_start while busy: ignored with no queuing. i_bin changes during SHIFT have no effect.
- Output holding:
  - o_D2, o_D1 and o_D0 change only at completion.
  - They hold their last result through subsequent IDLE and SHIFT periods.
- Reset mid-conversion: aborts immediately; all outputs return to 0; no o_done is produced.
- Arithmetic:
  - The add-3 is 4-bit; it never overflows because the nibble is <=9 before correction.
  - Results satisfy 100*o_D2 + 10*o_D1 + o_D0 = i_bin for all 256 inputs.
  - Every digit is always <=9.
- Reference step trace for i_bin=59:
  - Ones nibble reaches 7 before step 6, is corrected to 10, then shifts.
  - Final tens=0101, ones=1001.

Test Plan:
- Reset, then start with i_bin=59 -> o_done pulses exactly 8 edges after the accepting edge; o_D2=0, o_D1=5, o_D0=9; o_busy high for those 8 cycles.
- Boundary values:
  - i_bin=0 -> 0,0,0
  - i_bin=9 -> 0,0,9
  - i_bin=99 -> 0,9,9
  - i_bin=100 -> 1,0,0
  - i_bin=255 -> 2,5,5
- Exhaustive sweep 0..255 with back-to-back starts: each result matches the decimal digits; one o_done per start; starts are accepted on the edge after each o_done.
- Busy and input-change handling:
  - Start 128, then reassert i_start with i_bin=7 during SHIFT -> second start ignored; result 1,2,8; exactly one o_done.
  - Change i_bin mid-conversion -> result still reflects the latched 128.
- Reset mid-conversion:
  - After converting 59, start 200 and deassert i_rst_n at step 4 -> outputs immediately 0, o_busy=0, no o_done.
  - After release, start 200 -> 2,0,0.
- Output hold: after the 59 result, idle for 20 cycles with i_bin toggling and i_start=0 -> o_D1=5 and o_D0=9 unchanged; o_done stays 0.

Source files
------------

// File: rtl/tens.sv
// tens: sequential 8-bit binary to 3-digit BCD converter (double dabble).
// Ports: i_clk, i_rst_n, i_start, i_bin[7:0] in; o_busy, o_done, o_D2/o_D1/o_D0 out.
module tens (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_bin,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_D2,
  output logic [3:0] o_D1,
  output logic [3:0] o_D0
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [19:0] sr_q;
  logic [2:0]  cnt_q;
  logic [19:0] adj;
  logic [19:0] shifted;
  logic        last;

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Corrections use pre-step nibbles, then the whole word shifts.
  always_comb begin
    adj     = {add3(sr_q[19:16]),
               add3(sr_q[15:12]),
               add3(sr_q[11:8]),
               sr_q[7:0]};
    shifted = {adj[18:0], 1'b0};
    last    = (cnt_q == 3'd7);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = SHIFT;
      SHIFT:   if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_D2   <= '0;
      o_D1   <= '0;
      o_D0   <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            sr_q   <= {12'b0, i_bin};
            cnt_q  <= '0;
            o_busy <= 1'b1;
          end
        end
        SHIFT: begin
          sr_q  <= shifted;
          cnt_q <= cnt_q + 3'd1;
          if (last) begin
            o_D2   <= shifted[19:16];
            o_D1   <= shifted[15:12];
            o_D0   <= shifted[11:8];
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tens.sv
// tb_tens: self-checking bench for tens with a decimal-arithmetic model.
// Drives directed vectors and a full sweep; compares every cycle.
module tb_tens;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_bin = 8'd0;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_D2;
  logic [3:0] o_D1;
  logic [3:0] o_D0;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit chk_on = 1'b0;

  // model state
  bit       m_busy = 0;
  bit       m_done = 0;
  int       m_left = 0;
  int       m_val = 0;
  int       m_d2 = 0;
  int       m_d1 = 0;
  int       m_d0 = 0;

  tens dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_bin  (i_bin),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_D2   (o_D2),
    .o_D1   (o_D1),
    .o_D0   (o_D0)
  );

  always #5 i_clk = ~i_clk;

  // Model: a conversion takes 8 edges after acceptance, then the
  // digits are the decimal digits of the latched value.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0;
      m_d2 = 0; m_d1 = 0; m_d0 = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          m_d2 = m_val / 100;
          m_d1 = (m_val / 10) % 10;
          m_d0 = m_val % 10;
        end
      end else if (i_start) begin
        m_busy = 1;
        m_left = 8;
        m_val = int'(i_bin);
      end
    end
  end

  always @(negedge i_clk) begin
    if (o_done) done_cnt++;
    if (chk_on) begin
      n_tests++;
      if (o_busy !== m_busy || o_done !== m_done ||
          int'(o_D2) != m_d2 || int'(o_D1) != m_d1 ||
          int'(o_D0) != m_d0 || $isunknown({o_D2, o_D1, o_D0})) begin
        n_fail++;
        $display("FAIL model t=%0t got b%0b d%0b %0d%0d%0d want b%0b d%0b %0d%0d%0d",
          $time, o_busy, o_done, o_D2, o_D1, o_D0,
          m_busy, m_done, m_d2, m_d1, m_d0);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_dig(input string name, input int d2, input int d1,
                           input int d0);
    check({name, ".d2"}, int'(o_D2), d2);
    check({name, ".d1"}, int'(o_D1), d1);
    check({name, ".d0"}, int'(o_D0), d0);
  endtask

  // Call at a negedge; returns one negedge after the accepting edge.
  task automatic start_conv(input logic [7:0] v);
    i_start = 1'b1;
    i_bin = v;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Returns at the negedge where o_done is seen.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (o_done !== 1'b1 && lat < 20) begin
      if (o_busy) bcnt++;
      @(negedge i_clk);
      lat++;
    end
    if (o_done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout waiting for o_done");
    end
  endtask

  task automatic convert(input logic [7:0] v, output int lat, output int bcnt);
    start_conv(v);
    wait_done(lat, bcnt);
  endtask

  int lat, bcnt, dc0;

  initial begin
    repeat (3) @(negedge i_clk);
    chk_on = 1'b1;
    check("rst.busy", int'(o_busy), 0);
    check("rst.done", int'(o_done), 0);
    check_dig("rst", 0, 0, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    convert(8'd59, lat, bcnt);
    check("lat59", lat, 8);
    check("busy59", bcnt, 8);
    check_dig("c59", 0, 5, 9);
    @(negedge i_clk);
    check("done1cyc", int'(o_done), 0);

    convert(8'd0, lat, bcnt);   check_dig("c0", 0, 0, 0);
    @(negedge i_clk);
    convert(8'd9, lat, bcnt);   check_dig("c9", 0, 0, 9);
    @(negedge i_clk);
    convert(8'd99, lat, bcnt);  check_dig("c99", 0, 9, 9);
    @(negedge i_clk);
    convert(8'd100, lat, bcnt); check_dig("c100", 1, 0, 0);
    @(negedge i_clk);
    convert(8'd255, lat, bcnt); check_dig("c255", 2, 5, 5);
    @(negedge i_clk);

    // back-to-back sweep: each start issued at the o_done negedge
    #1 dc0 = done_cnt;
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), lat, bcnt);
      if (v > 0) check("sweep.lat", lat, 8);
      n_tests++;
      if (100 * int'(o_D2) + 10 * int'(o_D1) + int'(o_D0) != v ||
          o_D1 > 4'd9 || o_D0 > 4'd9) begin
        n_fail++;
        $display("FAIL sweep v=%0d got %0d%0d%0d", v, o_D2, o_D1, o_D0);
      end
    end
    #1 check("sweep.dones", done_cnt - dc0, 256);
    @(negedge i_clk);

    // start while busy is ignored; i_bin changes do nothing
    #1 dc0 = done_cnt;
    start_conv(8'd128);
    @(negedge i_clk);
    i_start = 1'b1; i_bin = 8'd7;
    @(negedge i_clk);
    i_start = 1'b0; i_bin = 8'd33;
    @(negedge i_clk);
    i_bin = 8'd250;
    wait_done(lat, bcnt);
    check_dig("c128", 1, 2, 8);
    repeat (12) @(negedge i_clk);
    #1 check("busy.dones", done_cnt - dc0, 1);

    // reset mid-conversion
    @(negedge i_clk);
    convert(8'd59, lat, bcnt);
    @(negedge i_clk);
    #1 dc0 = done_cnt;
    start_conv(8'd200);
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("rstmid.busy", int'(o_busy), 0);
    check("rstmid.done", int'(o_done), 0);
    check_dig("rstmid", 0, 0, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    #1 check("rstmid.dones", done_cnt - dc0, 0);
    @(negedge i_clk);
    convert(8'd200, lat, bcnt);
    check_dig("c200", 2, 0, 0);

    // hold after 59 result
    @(negedge i_clk);
    convert(8'd59, lat, bcnt);
    @(negedge i_clk);
    #1 dc0 = done_cnt;
    for (int k = 0; k < 20; k++) begin
      i_bin = 8'($urandom_range(0, 255));
      @(negedge i_clk);
    end
    check_dig("hold", 0, 5, 9);
    #1 check("hold.dones", done_cnt - dc0, 0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

endmodule
